// File: rtl/spi_memory_fsm.sv
// SPI memory transaction controller: counts SCLK edges for the address/command
// word and the data word, and issues the single-cycle write strobes for each phase.
module spi_memory_fsm #(
   parameter int WORD_BITS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       chipSelect,
   input  logic       sclkPosEdge,
   input  logic       sclkNegEdge,
   input  logic       readWrite,
   output logic       addrWE,
   output logic       dmWE,
   output logic       srWE,
   output logic       misoBufe,
   output logic [2:0] state
);

   localparam int CNT_W = $clog2(WORD_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_GET_ADDR    = 3'd1,
      ST_GOT_ADDR    = 3'd2,
      ST_READ_LOAD   = 3'd3,
      ST_READ_SHIFT  = 3'd4,
      ST_WRITE_GET   = 3'd5,
      ST_WRITE_STORE = 3'd6,
      ST_DONE        = 3'd7
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] w_bit_cnt_next;
   logic             w_count_pulse;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_bit_cnt <= w_bit_cnt_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_bit_cnt_next = r_bit_cnt;
      w_count_pulse  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!chipSelect) w_state_next = ST_GET_ADDR;
         end
         ST_GET_ADDR: begin
            w_count_pulse = sclkPosEdge;
            if (sclkPosEdge && (r_bit_cnt == LAST_BIT)) w_state_next = ST_GOT_ADDR;
         end
         ST_GOT_ADDR: begin
            w_state_next = readWrite ? ST_READ_LOAD : ST_WRITE_GET;
         end
         ST_READ_LOAD: begin
            w_state_next = ST_READ_SHIFT;
         end
         ST_READ_SHIFT: begin
            // MISO data is launched on falling edges, so only those are counted here
            w_count_pulse = sclkNegEdge;
            if (sclkNegEdge && (r_bit_cnt == LAST_BIT)) w_state_next = ST_DONE;
         end
         ST_WRITE_GET: begin
            w_count_pulse = sclkPosEdge;
            if (sclkPosEdge && (r_bit_cnt == LAST_BIT)) w_state_next = ST_WRITE_STORE;
         end
         ST_WRITE_STORE: begin
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            if (chipSelect) w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      if (w_count_pulse) w_bit_cnt_next = r_bit_cnt + CNT_W'(1);

      // Deselect aborts any transaction in flight
      if (chipSelect && (r_state != ST_IDLE)) w_state_next = ST_IDLE;

      if (w_state_next != r_state) w_bit_cnt_next = '0;
   end

   assign addrWE   = (r_state == ST_GOT_ADDR);
   assign srWE     = (r_state == ST_READ_LOAD);
   assign dmWE     = (r_state == ST_WRITE_STORE);
   assign misoBufe = (r_state == ST_READ_SHIFT);
   assign state    = r_state;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Directed bench for spi_memory_fsm: write, read, abort, reset, back-to-back and stray-edge cases.
module tb_spi_memory_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       chipSelect;
   logic       sclkPosEdge;
   logic       sclkNegEdge;
   logic       readWrite;
   logic       addrWE;
   logic       dmWE;
   logic       srWE;
   logic       misoBufe;
   logic [2:0] state;

   int n_checks = 0;
   int n_pass   = 0;
   int cnt_addr, cnt_dm, cnt_sr;
   int multi_strobe = 0;
   int repeat_strobe = 0;
   logic prev_addr = 1'b0, prev_dm = 1'b0, prev_sr = 1'b0;

   spi_memory_fsm #(.WORD_BITS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .chipSelect  (chipSelect),
      .sclkPosEdge (sclkPosEdge),
      .sclkNegEdge (sclkNegEdge),
      .readWrite   (readWrite),
      .addrWE      (addrWE),
      .dmWE        (dmWE),
      .srWE        (srWE),
      .misoBufe    (misoBufe),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
   endtask

   // One clock: apply inputs, let the DUT sample them, observe 1 time unit later
   task automatic tick(input logic cs, input logic pe, input logic ne, input logic rw);
      chipSelect  = cs;
      sclkPosEdge = pe;
      sclkNegEdge = ne;
      readWrite   = rw;
      @(posedge clk);
      #1;
      if ((32'(addrWE) + 32'(dmWE) + 32'(srWE)) > 1) multi_strobe++;
      if ((addrWE && prev_addr) || (dmWE && prev_dm) || (srWE && prev_sr)) repeat_strobe++;
      if (addrWE) cnt_addr++;
      if (dmWE)   cnt_dm++;
      if (srWE)   cnt_sr++;
      prev_addr   = addrWE;
      prev_dm     = dmWE;
      prev_sr     = srWE;
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
   endtask

   task automatic clear_counts();
      cnt_addr = 0;
      cnt_dm   = 0;
      cnt_sr   = 0;
   endtask

   // n rising-edge pulses; gap cycles carry falling-edge pulses, pulse 2 carries both
   task automatic send_pos(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, 1'b1, (i == 2), 1'b0);
         if (i < n - 1) tick(1'b0, 1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic send_neg(input int n);
      for (int i = 0; i < n; i++) begin
         tick(1'b0, (i == 2), 1'b1, 1'b0);
         if (i < n - 1) tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic do_write(input string pfx);
      clear_counts();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_enter_state"}, 32'(state), 1);
      send_pos(7);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check_val({pfx, "_addr7_state"}, 32'(state), 1);
      send_pos(1);
      check_val({pfx, "_addrWE"}, 32'(addrWE), 1);
      check_val({pfx, "_got_state"}, 32'(state), 2);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_wget_state"}, 32'(state), 5);
      send_pos(7);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check_val({pfx, "_data7_state"}, 32'(state), 5);
      send_pos(1);
      check_val({pfx, "_dmWE"}, 32'(dmWE), 1);
      check_val({pfx, "_store_state"}, 32'(state), 6);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_done_state"}, 32'(state), 7);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_idle_state"}, 32'(state), 0);
      check_val({pfx, "_n_addrWE"}, 32'(cnt_addr), 1);
      check_val({pfx, "_n_dmWE"}, 32'(cnt_dm), 1);
      check_val({pfx, "_n_srWE"}, 32'(cnt_sr), 0);
   endtask

   // Runs a read up to READ_SHIFT entry and checks the k+1/k+2/k+3 sequence
   task automatic read_to_shift(input string pfx);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_enter_state"}, 32'(state), 1);
      send_pos(8);
      check_val({pfx, "_addrWE"}, 32'(addrWE), 1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check_val({pfx, "_srWE"}, 32'(srWE), 1);
      check_val({pfx, "_load_state"}, 32'(state), 3);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_misoBufe_on"}, 32'(misoBufe), 1);
      check_val({pfx, "_shift_state"}, 32'(state), 4);
   endtask

   task automatic do_read(input string pfx);
      clear_counts();
      read_to_shift(pfx);
      send_neg(7);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check_val({pfx, "_misoBufe_hold"}, 32'(misoBufe), 1);
      send_neg(1);
      check_val({pfx, "_misoBufe_off"}, 32'(misoBufe), 0);
      check_val({pfx, "_done_state"}, 32'(state), 7);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check_val({pfx, "_idle_state"}, 32'(state), 0);
      check_val({pfx, "_n_addrWE"}, 32'(cnt_addr), 1);
      check_val({pfx, "_n_srWE"}, 32'(cnt_sr), 1);
      check_val({pfx, "_n_dmWE"}, 32'(cnt_dm), 0);
   endtask

   initial begin
      reset       = 1'b1;
      chipSelect  = 1'b1;
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
      readWrite   = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check_val("rst_state", 32'(state), 0);
      check_val("rst_outs", {28'd0, addrWE, dmWE, srWE, misoBufe}, 0);

      do_write("wr");
      do_read("rd");

      // Reset in the middle of the data phase of a read
      clear_counts();
      read_to_shift("rstmid");
      send_neg(3);
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check_val("rstmid_state", 32'(state), 0);
      check_val("rstmid_outs", {28'd0, addrWE, dmWE, srWE, misoBufe}, 0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_val("cs_high_pulses_state", 32'(state), 0);

      // Abort during the address phase, then a clean write
      clear_counts();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      send_pos(4);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("abort_state", 32'(state), 0);
      check_val("abort_strobes", 32'(cnt_addr + cnt_dm + cnt_sr), 0);
      do_write("post_abort");

      // Back-to-back: read, one deselected cycle (inside do_read), write
      do_read("b2b_rd");
      do_write("b2b_wr");

      // Stray edges: pulse on the CS-low entry cycle and pulses while in DONE
      clear_counts();
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("stray_entry_state", 32'(state), 1);
      send_pos(7);
      check_val("stray_entry_no_addrWE", 32'(addrWE), 0);
      check_val("stray_entry_state7", 32'(state), 1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      send_pos(1);
      check_val("stray_addrWE", 32'(addrWE), 1);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      send_pos(8);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_val("stray_done_state", 32'(state), 7);
      clear_counts();
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 1'b1, 1'b0);
      end
      check_val("stray_done_hold", 32'(state), 7);
      check_val("stray_done_strobes", 32'(cnt_addr + cnt_dm + cnt_sr), 0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check_val("stray_idle_state", 32'(state), 0);

      check_val("multi_strobe_cycles", 32'(multi_strobe), 0);
      check_val("repeat_strobe_cycles", 32'(repeat_strobe), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
